// File: rtl/disp_scan_ctrl.sv
// Multiplexed 8-digit display scanner with double-buffered frame handshake and per-slot dead time.
// Optional PWM brightness when DISP_SCAN_BRIGHTNESS_EN is defined.
module disp_scan_ctrl #(
  parameter int unsigned SLOT_CYC  = 83_333,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_valid,
  input  logic [63:0] frame_data,
  output logic        frame_ready,
  input  logic [2:0]  bright,
  output logic        frame_done,
  output logic [15:0] DISPLAY
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYC);
  localparam int unsigned ON_W  = CNT_W + 4;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  // Packed as bytes so index 7 is digit 0 (frame_data[63:56]).
  typedef logic [7:0][7:0] frame_t;

  logic [CNT_W-1:0] slot_q, slot_d;
  logic [2:0]       dig_q, dig_d;
  frame_t           shadow_q, shadow_d;
  frame_t           active_q, active_d;
  logic             shadow_full_q, shadow_full_d;
  logic             active_vld_q, active_vld_d;
  logic             frame_ready_q, frame_ready_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      display_q, display_d;
  logic             boundary;
  logic             on_phase;
  logic [7:0]       anode;

`ifdef DISP_SCAN_BRIGHTNESS_EN
  logic [2:0]       bright_q, bright_d;
  logic [ON_W-1:0]  span;
  logic [ON_W-1:0]  on_prod;
  logic [ON_W-1:0]  on_end;

  // on_len = span*(bright+1)/8, evaluated in ON_W bits so it cannot overflow.
  always_comb begin
    span     = ON_W'(SLOT_CYC - BLANK_CYC);
    on_prod  = span * ON_W'(bright_q) + span;
    on_end   = ON_W'(BLANK_CYC) + (on_prod >> 3);
    on_phase = (slot_q >= BLANK_END) && (ON_W'(slot_q) < on_end);
    bright_d = bright_q;
    if (en && (slot_q == '0)) bright_d = bright;
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign on_phase      = (slot_q >= BLANK_END);
`endif

  assign anode = ~(8'h80 >> dig_q);

  always_comb begin
    slot_d        = slot_q;
    dig_d         = dig_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    shadow_full_d = shadow_full_q;
    active_vld_d  = active_vld_q;
    display_d     = 16'hFFFF;

    if (!en) begin
      slot_d = '0;
      dig_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      dig_d  = dig_q + 3'd1;
    end else begin
      slot_d = slot_q + CNT_W'(1);
    end

    // Swap only uses the pre-cycle full flag, so a same-cycle accept waits a frame.
    boundary = en && (slot_q == '0) && (dig_q == '0);
    if (boundary && shadow_full_q) begin
      active_d      = shadow_q;
      active_vld_d  = 1'b1;
      shadow_full_d = 1'b0;
    end
    if (frame_valid && frame_ready_q) begin
      shadow_d      = frame_data;
      shadow_full_d = 1'b1;
    end

    frame_ready_d = !shadow_full_d;
    frame_done_d  = en && (dig_d == 3'd7) && (slot_d == SLOT_LAST);

    if (en && on_phase && active_vld_q) display_d = {active_q[~dig_q], anode};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      dig_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '1;
      shadow_full_q <= 1'b0;
      active_vld_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      display_q     <= 16'hFFFF;
`ifdef DISP_SCAN_BRIGHTNESS_EN
      bright_q      <= '0;
`endif
    end else begin
      slot_q        <= slot_d;
      dig_q         <= dig_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      active_vld_q  <= active_vld_d;
      frame_ready_q <= frame_ready_d;
      frame_done_q  <= frame_done_d;
      display_q     <= display_d;
`ifdef DISP_SCAN_BRIGHTNESS_EN
      bright_q      <= bright_d;
`endif
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign DISPLAY     = display_q;

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_CYC, default 83_333, meaning clk cycles per digit slot (600 Hz digit rate, 75 Hz frame at 50 MHz); legal range 8..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 500, meaning dead-time cycles at the start of each slot; legal range 1..SLOT_CYC-2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: scan enable.
REQ-006 SHALL have port frame_valid, input, 1 bit: a new frame is offered.
REQ-007 SHALL have port frame_data, input, 64 bits: eight active-low segment bytes; [63:56] is digit 0 (leftmost), [7:0] is digit 7.
REQ-008 SHALL have port frame_ready, output, 1 bit: shadow buffer empty, frame can be accepted.
REQ-009 SHALL have port bright, input, 3 bits: brightness level; used only with the macro in REQ-030.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of digit 7's slot.
REQ-011 SHALL have port DISPLAY, output, 16 bits: {segments[7:0], anodes[7:0]}, both active-low.

Function
REQ-012 Digit index d (0..7) SHALL advance by one at each slot end and wrap 7->0; slot_cnt counts 0..SLOT_CYC-1.
REQ-013 Digit d's anode byte SHALL be all ones except bit 7-d, which is 0 (d=0 -> 8'b01111111, d=7 -> 8'b11111110).
REQ-014 Each slot SHALL have three phases: BLANK for slot_cnt < BLANK_CYC; ON for BLANK_CYC <= slot_cnt < BLANK_CYC+on_len; OFF for the remainder of the slot.
REQ-015 In BLANK and OFF, DISPLAY SHALL be 16'hFFFF; in ON, DISPLAY SHALL be {active[d], anode(d)}.
REQ-016 DISPLAY SHALL be registered, showing the phase of slot_cnt value c on the edge after c (1-cycle latency).
REQ-017 Handshake: a frame SHALL be accepted when frame_valid && frame_ready at a rising edge; frame_data is written to the shadow buffer and frame_ready goes low on the next cycle.
REQ-018 At slot_cnt==0 of digit 0 (frame boundary), if the shadow was full before that cycle, it SHALL be copied to the active buffer and frame_ready SHALL return high on the next cycle.
REQ-019 A frame accepted in the same cycle as a boundary SHALL NOT be swapped at that boundary; it waits for the next one.
REQ-020 The active buffer SHALL change only at a frame boundary, so a frame is never torn mid-scan.
REQ-021 frame_done SHALL be high for exactly the cycle in which d==7 and slot_cnt==SLOT_CYC-1.
REQ-022 When en is low, DISPLAY SHALL be 16'hFFFF, slot_cnt and d SHALL be held at 0, frame_done SHALL be 0, and the handshake SHALL remain operational.
REQ-023 When en rises, scanning SHALL restart at d=0, slot_cnt=0, and that cycle counts as a frame boundary.
REQ-024 frame_valid while frame_ready is low SHALL be ignored; the held data is not overwritten.

Reset
REQ-025 While rst is high: DISPLAY=16'hFFFF, frame_ready=0, frame_done=0, d=0, slot_cnt=0, shadow empty, all active bytes 8'hFF.
REQ-026 frame_ready SHALL be 1 on the first cycle after rst falls.
REQ-027 rst SHALL have priority over en and the handshake; rst asserted mid-slot or mid-handshake discards the shadow contents.

Configuration
REQ-028 Without DISP_SCAN_BRIGHTNESS_EN, on_len SHALL be SLOT_CYC-BLANK_CYC, there SHALL be no OFF phase, and bright SHALL be ignored.
REQ-029 With DISP_SCAN_BRIGHTNESS_EN, on_len SHALL be ((SLOT_CYC-BLANK_CYC)*(bright+1))>>3, computed without overflow.
REQ-030 With DISP_SCAN_BRIGHTNESS_EN, bright SHALL be sampled at slot_cnt==0 and held for that slot.

Verification (SLOT_CYC=16, BLANK_CYC=2)
REQ-031 Reset then en=1, no frame -> DISPLAY 16'hFFFF throughout; frame_done pulses every 128 cycles.
REQ-032 Offer frame 64'h03_9F_25_0D_99_49_41_1F -> frame_ready low one cycle later; after the next boundary, digit 0 ON shows 16'h037F and digit 7 ON shows 16'h1FFE; each digit shows 2 blank cycles then 14 ON cycles.
REQ-033 frame_valid held for two frames back-to-back -> second frame ignored until frame_ready returns; no mid-frame change of segments.
REQ-034 Accept a frame exactly at a boundary cycle -> it is displayed from the following boundary (128 cycles later).
REQ-035 Macro on, bright=3 -> 7 ON cycles and 7 OFF cycles per slot; bright=7 -> 14 ON cycles; bright change mid-slot takes effect next slot.
REQ-036 rst pulsed mid-slot with the shadow full -> DISPLAY 16'hFFFF, frame_ready=1 after release, old frame lost; en low mid-slot -> blank output, restart at digit 0 on re-enable.
